// File: rtl/result_dumper_pkg.sv
// Shared types and constants for the result dump path and its sibling loader.
package result_dumper_pkg;

  localparam int ADDR_W = 12;
  localparam int WORD_W = 12;
  localparam int BYTE_W = 8;

  // Frame sync byte, also known to the UART loader and the host script.
  localparam logic [BYTE_W-1:0] DEFAULT_HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD_ADDR,
    RD_WAIT,
    SEND_HI,
    SEND_LO,
    DONE
  } state_t;

endpackage

// File: rtl/matrix_addr_gen.sv
// Row-major matrix address walker: row-base register plus column offset, 12-bit wrap.
module matrix_addr_gen
  import result_dumper_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int BASE_ADDR  = 4,
  parameter int ROW_STRIDE = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(ROW_STRIDE);
  localparam logic [ADDR_W-1:0] ROW_MAX  = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COL_MAX  = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  logic [ADDR_W-1:0] row_q;
  logic [ADDR_W-1:0] col_q;
  logic [ADDR_W-1:0] row_base_q;
  logic              col_last;
  logic              row_last;

  assign col_last = (col_q == COL_MAX);
  assign row_last = (row_q == ROW_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q      <= '0;
      col_q      <= '0;
      row_base_q <= '0;
    end else if (clear) begin
      row_q      <= '0;
      col_q      <= '0;
      row_base_q <= BASE_A;
    end else if (advance) begin
      if (col_last) begin
        col_q      <= '0;
        row_q      <= row_q + ONE;
        row_base_q <= row_base_q + STRIDE_A;
      end else begin
        col_q <= col_q + ONE;
      end
    end
  end

  // Sum wraps naturally past 4095 back to 0.
  assign addr = row_base_q + col_q;
  assign last = row_last && col_last;

endmodule

// File: rtl/result_dumper.sv
// Streams a result matrix from a data-memory bank as a byte frame:
// header, then each 12-bit word as {4'b0, w[11:8]}, w[7:0] in row-major order.
module result_dumper
  import result_dumper_pkg::*;
#(
  parameter int                ROWS       = 4,
  parameter int                COLS       = 4,
  parameter int                BASE_ADDR  = 4,
  parameter int                ROW_STRIDE = 64,
  parameter logic [BYTE_W-1:0] HDR_BYTE   = DEFAULT_HDR_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  input  logic [WORD_W-1:0] mem_dataout,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  // tx handshake: one byte moves on each rising edge with tx_valid && tx_ready;
  // until then tx_valid stays high and tx_data is held unchanged.

  state_t            state_q, state_d;
  logic              busy_d, done_d, tx_valid_d;
  logic [BYTE_W-1:0] tx_data_d;
  logic [BYTE_W-1:0] lo_q, lo_d;  // only the low byte is needed after RD_WAIT
  logic              clear, advance, last;
  logic              hs;

  assign hs           = tx_valid && tx_ready;
  assign mem_write_en = 1'b0;

  matrix_addr_gen #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .BASE_ADDR (BASE_ADDR),
    .ROW_STRIDE(ROW_STRIDE)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .advance(advance),
    .addr   (mem_addr),
    .last   (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      busy     <= busy_d;
      done     <= done_d;
      tx_valid <= tx_valid_d;
      tx_data  <= tx_data_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy;
    done_d     = 1'b0;
    tx_valid_d = tx_valid;
    tx_data_d  = tx_data;
    lo_d       = lo_q;
    clear      = 1'b0;
    advance    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = HDR;
          busy_d     = 1'b1;
          tx_data_d  = HDR_BYTE;
          tx_valid_d = 1'b1;
          clear      = 1'b1;
        end
      end
      HDR: begin
        if (hs) begin
          state_d    = RD_ADDR;
          tx_valid_d = 1'b0;
        end
      end
      RD_ADDR: state_d = RD_WAIT;
      RD_WAIT: begin
        lo_d       = mem_dataout[BYTE_W-1:0];
        tx_data_d  = {{(2*BYTE_W-WORD_W){1'b0}}, mem_dataout[WORD_W-1:BYTE_W]};
        tx_valid_d = 1'b1;
        state_d    = SEND_HI;
      end
      SEND_HI: begin
        if (hs) begin
          tx_data_d = lo_q;
          state_d   = SEND_LO;
        end
      end
      SEND_LO: begin
        if (hs) begin
          tx_valid_d = 1'b0;
          if (last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            advance = 1'b1;
            state_d = RD_ADDR;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_dumper.sv
// Directed bench for result_dumper: default 4x4 instance plus a 1x8 wrapping instance.
module tb_result_dumper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start_a = 1'b0, tx_ready_a = 1'b1;
  logic        busy_a, done_a, we_a, tx_valid_a;
  logic [11:0] addr_a, dout_a;
  logic [7:0]  tx_data_a;

  logic        start_b = 1'b0, tx_ready_b = 1'b1;
  logic        busy_b, done_b, we_b, tx_valid_b;
  logic [11:0] addr_b, dout_b;
  logic [7:0]  tx_data_b;

  logic [11:0] tb_mem [0:4095];

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_qb[$];
  logic [11:0] addr_q[$];
  logic [11:0] addr_qb[$];
  int          acc_a = 0, acc_b = 0, done_cnt_a = 0, done_cnt_b = 0;
  bit          we_seen = 0;

  result_dumper u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .mem_addr(addr_a), .mem_write_en(we_a), .mem_dataout(dout_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a)
  );

  result_dumper #(.ROWS(1), .COLS(8), .BASE_ADDR(4090)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .mem_addr(addr_b), .mem_write_en(we_b), .mem_dataout(dout_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b)
  );

  // clock / memory model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    dout_a <= tb_mem[addr_a];
    dout_b <= tb_mem[addr_b];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input bit b, input int rows, input int cols,
                            input int base, input int stride);
    logic [11:0] a;
    logic [11:0] w;
    if (b) exp_qb.push_back(8'hA5);
    else   exp_q.push_back(8'hA5);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        a = 12'(base + r * stride + c);
        w = tb_mem[a];
        if (b) begin
          exp_qb.push_back({4'h0, w[11:8]});
          exp_qb.push_back(w[7:0]);
          addr_qb.push_back(a);
        end else begin
          exp_q.push_back({4'h0, w[11:8]});
          exp_q.push_back(w[7:0]);
          addr_q.push_back(a);
        end
      end
    end
  endtask

  task automatic pulse_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(output int cyc);
    cyc = 1;
    while (!done_a && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  task automatic frame_end_a(input string tag);
    chk({tag, "_bytes_left"}, 32'(exp_q.size()), 0);
    chk({tag, "_addrs_left"}, 32'(addr_q.size()), 0);
  endtask

  // scoreboard monitors
  logic        stall_a = 1'b0;
  logic [7:0]  stall_d_a;
  bit          have_a = 0, have_b = 0;
  logic [11:0] last_a, last_b;
  logic [31:0] e_a, e_b;

  always @(negedge clk) begin
    if (rst) begin
      stall_a = 1'b0;
      have_a  = 0;
    end else begin
      if (we_a || we_b) we_seen = 1;
      if (done_a) done_cnt_a++;
      if (stall_a) begin
        chk("stall_valid_a", tx_valid_a, 1);
        chk("stall_data_a", tx_data_a, stall_d_a);
      end
      stall_a   = tx_valid_a && !tx_ready_a;
      stall_d_a = tx_data_a;
      if (tx_valid_a && tx_ready_a) begin
        acc_a++;
        e_a = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
        chk("byte_a", tx_data_a, e_a);
      end
      if (busy_a) begin
        if (!have_a || addr_a != last_a) begin
          e_a = (addr_q.size() > 0) ? 32'(addr_q.pop_front()) : 32'hFFFF_FFFF;
          chk("addr_a", addr_a, e_a);
        end
        have_a = 1;
        last_a = addr_a;
      end else begin
        have_a = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      have_b = 0;
    end else begin
      if (done_b) done_cnt_b++;
      if (tx_valid_b && tx_ready_b) begin
        acc_b++;
        e_b = (exp_qb.size() > 0) ? 32'(exp_qb.pop_front()) : 32'hDEAD_BEEF;
        chk("byte_b", tx_data_b, e_b);
      end
      if (busy_b) begin
        if (!have_b || addr_b != last_b) begin
          e_b = (addr_qb.size() > 0) ? 32'(addr_qb.pop_front()) : 32'hFFFF_FFFF;
          chk("addr_b", addr_b, e_b);
        end
        have_b = 1;
        last_b = addr_b;
      end else begin
        have_b = 0;
      end
    end
  end

  // directed sequence
  initial begin
    int cyc, k, a0, d0;
    for (int i = 0; i < 4096; i++) tb_mem[i] = 12'h000;
    for (int i = 0; i < 16; i++) tb_mem[12'(4 + (i / 4) * 64 + i % 4)] = 12'(i + 1);

    // reset state
    #12;
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_valid_a", tx_valid_a, 0);
    chk("rst_data_a", tx_data_a, 0);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_we_a", we_a, 0);
    chk("rst_valid_b", tx_valid_b, 0);
    chk("rst_addr_b", addr_b, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // full-throughput frame
    push_frame(0, 4, 4, 4, 64);
    a0 = acc_a;
    d0 = done_cnt_a;
    pulse_a();
    chk("s1_hdr_valid", tx_valid_a, 1);
    chk("s1_hdr_data", tx_data_a, 8'hA5);
    chk("s1_hdr_busy", busy_a, 1);
    wait_done_a(cyc);
    chk("s1_done_cycles", cyc, 66);
    chk("s1_done_busy", busy_a, 1);
    tick();
    chk("s1_done_pulse", done_a, 0);
    chk("s1_busy_clear", busy_a, 0);
    chk("s1_done_count", done_cnt_a - d0, 1);
    chk("s1_len", acc_a - a0, 33);
    frame_end_a("s1");

    // backpressure
    push_frame(0, 4, 4, 4, 64);
    a0 = acc_a;
    pulse_a();
    tick();
    k = 0;
    while (!tx_valid_a && k < 10) begin
      tick();
      k++;
    end
    chk("s2_hi_valid", tx_valid_a, 1);
    tx_ready_a = 1'b0;
    repeat (5) tick();
    chk("s2_stall_valid", tx_valid_a, 1);
    chk("s2_stall_data", tx_data_a, 8'h00);
    k = 0;
    while (!done_a && k < 1000) begin
      tx_ready_a = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    chk("s2_done_seen", done_a, 1);
    tx_ready_a = 1'b1;
    tick();
    chk("s2_len", acc_a - a0, 33);
    frame_end_a("s2");

    // extreme element values
    tb_mem[4] = 12'hFFF;
    tb_mem[5] = 12'h000;
    push_frame(0, 4, 4, 4, 64);
    pulse_a();
    wait_done_a(cyc);
    chk("s3_done_cycles", cyc, 66);
    tick();
    frame_end_a("s3");

    // start while busy, then restart right after done
    push_frame(0, 4, 4, 4, 64);
    d0 = done_cnt_a;
    pulse_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (20) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done_a(cyc);
    chk("s4_done", done_a, 1);
    push_frame(0, 4, 4, 4, 64);
    start_a = 1'b1;
    tick();
    chk("s4_idle_busy", busy_a, 0);
    chk("s4_idle_valid", tx_valid_a, 0);
    tick();
    start_a = 1'b0;
    chk("s4_restart_valid", tx_valid_a, 1);
    chk("s4_restart_hdr", tx_data_a, 8'hA5);
    wait_done_a(cyc);
    chk("s4_done_cycles", cyc, 66);
    tick();
    chk("s4_done_count", done_cnt_a - d0, 2);
    frame_end_a("s4");

    // async reset mid-frame
    push_frame(0, 4, 4, 4, 64);
    a0 = acc_a;
    pulse_a();
    k = 0;
    while (acc_a < a0 + 10 && k < 200) begin
      tick();
      k++;
    end
    chk("s5_ten_bytes", acc_a - a0, 10);
    #2 rst = 1'b1;
    #1;
    chk("s5_rst_valid", tx_valid_a, 0);
    chk("s5_rst_busy", busy_a, 0);
    chk("s5_rst_addr", addr_a, 0);
    exp_q.delete();
    addr_q.delete();
    tick();
    rst = 1'b0;
    tick();
    push_frame(0, 4, 4, 4, 64);
    a0 = acc_a;
    pulse_a();
    chk("s5_hdr_data", tx_data_a, 8'hA5);
    wait_done_a(cyc);
    chk("s5_done_cycles", cyc, 66);
    tick();
    chk("s5_len", acc_a - a0, 33);
    frame_end_a("s5");

    // 1x8 frame wrapping past 4095
    for (int i = 0; i < 8; i++) tb_mem[12'(4090 + i)] = 12'(12'h3C0 + i * 17);
    push_frame(1, 1, 8, 4090, 64);
    a0 = acc_b;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cyc = 1;
    while (!done_b && cyc < 400) begin
      tick();
      cyc++;
    end
    chk("s6_done_cycles", cyc, 34);
    tick();
    chk("s6_len", acc_b - a0, 17);
    chk("s6_done_count", done_cnt_b, 1);
    chk("s6_bytes_left", 32'(exp_qb.size()), 0);
    chk("s6_addrs_left", 32'(addr_qb.size()), 0);
    chk("write_en_seen", we_seen, 0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/result_dumper.md
Name: result_dumper

Overview:
- Drains a completed result matrix out of one core's data-memory bank after a matrix multiply.
- Reads the matrix through the bank's registered read port (addr → dataout, 1-cycle latency).
- Serialises each 12-bit word into bytes on a valid/ready byte stream that feeds the UART transmitter.
- Sits directly downstream of the data memory, between it and the host-facing serial link.

Parameters:
- ROWS, 4, matrix rows to dump
- COLS, 4, matrix columns to dump
- BASE_ADDR, 4, word address of element [0][0]
- ROW_STRIDE, 64, address distance between consecutive rows
- HDR_BYTE, 8'hA5, frame sync byte sent first

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request one dump frame; sampled only in IDLE
- busy  out  1  high from accepted start through the done cycle
- done  out  1  one-cycle pulse after the last byte is accepted
- mem_addr  out  12  read address to the memory bank
- mem_write_en  out  1  memory write enable; constant 0
- mem_dataout  in  12  registered read data, valid one edge after mem_addr
- tx_data  out  8  byte to the UART transmitter
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  transmitter accepts a byte when valid && ready

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - busy, done, tx_valid, tx_data, mem_addr, and the row/col counters = 0.
  - mem_write_en is tied 0 at all times, so the bank's read port always updates.
- Frame format:
  - HDR_BYTE first.
  - Then, for each element in row-major order: high byte {4'b0, w[11:8]}, then low byte w[7:0].
  - Total length is 1 + 2·ROWS·COLS bytes (33 at defaults).
- Element address: (BASE_ADDR + row·ROW_STRIDE + col) mod 4096.
  - Generated incrementally: a row-base register plus a column offset.
  - 12-bit arithmetic with natural wrap; no multiplier.
- FSM:
  - IDLE: start=1 → HDR, busy←1, tx_data←HDR_BYTE, tx_valid←1. start=0 → stay.
  - HDR: on tx_valid && tx_ready → RD_ADDR with mem_addr = element [0][0]; tx_valid←0.
  - RD_ADDR: mem_addr is stable; unconditionally → RD_WAIT.
  - RD_WAIT: mem_addr is held; at the edge, capture mem_dataout into word_q; → SEND_HI with tx_data = {4'b0, word_q[11:8]}, tx_valid=1.
  - SEND_HI: on handshake → SEND_LO with tx_data = word_q[7:0].
  - SEND_LO, on handshake:
    - If the last element was sent → DONE, tx_valid←0.
    - Otherwise advance col. When col wraps at COLS-1, reset it to 0, increment row, and add ROW_STRIDE to the row base.
    - Then → RD_ADDR with the new mem_addr.
  - DONE: done=1 for exactly this cycle, busy=1; → IDLE. start is ignored in DONE.
- Handshake rules:
  - tx_data is held stable, and tx_valid never deasserts, until the byte is accepted.
  - Exactly one byte is transferred per valid && ready cycle; no duplicates, no drops.
  - tx_ready may toggle arbitrarily.
- Timing at full throughput (tx_ready=1):
  - Header is valid in the cycle after start is accepted.
  - Each element costs 4 cycles (RD_ADDR, RD_WAIT, SEND_HI, SEND_LO).
  - Defaults: 1 + 64 + 1 = 66 cycles from start to done.
- Boundary conditions:
  - start while busy is ignored, with no restart and no queueing.
  - rst mid-frame aborts the frame; the partial frame is not resumed. The host resyncs on HDR_BYTE.
  - ROWS=1 or COLS=1 must work. The address wraps past 4095 to 0.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, HDR, RD_ADDR, RD_WAIT, SEND_HI, SEND_LO, DONE);
  - ADDR_W=12, WORD_W=12, BYTE_W=8;
  - the default HDR_BYTE, shared with the UART loader and host script.
- One sub-module, matrix_addr_gen:
  - row/col counters, row-base register, mem_addr output;
  - control inputs: clear and advance;
  - status output: last;
  - reusable by the upstream loader.

Test Plan:
1. Preload the matrix at addresses 4..7, 68..71, 132..135 and 196..199 with values 1..16, then pulse start with tx_ready=1.
   - Bytes are A5,00,01,00,02,…,00,10 (33 total).
   - mem_addr sequence is 4,5,6,7,68,…,199.
   - done pulses once, 66 cycles after start; mem_write_en stays 0 throughout.
2. Backpressure: tx_ready low for 5 cycles during a SEND_HI, then a random 50% duty pattern.
   - tx_data is stable while stalled.
   - The byte stream is identical to scenario 1.
3. Element value 12'hFFF, then 12'h000.
   - Bytes are 0F,FF, then 00,00.
4. start is re-asserted in the HDR, mid-frame and DONE cycles.
   - Only one frame is produced.
   - start in the cycle after done begins a new frame (header on the next cycle).
5. rst asserted asynchronously after the 10th byte.
   - tx_valid, busy and mem_addr go to 0 immediately.
   - A subsequent start produces a complete 33-byte frame starting with A5.
6. Override BASE_ADDR=4090, ROWS=1, COLS=8.
   - mem_addr is 4090..4095, 0, 1.
   - Frame length is 17 bytes.
